// File: rtl/analogizer_csync_gen.sv
// Broadcast-style composite sync generator: measures line period and HS width,
// then serrates VS once timing is stable. Optional equalizing pulses: CSYNC_EQ_EN.
module analogizer_csync_gen #(
  parameter int LINE_W   = 12,
  parameter int MIN_LINE = 64,
  parameter int EQ_LINES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hs,
  input  logic              i_vs,
  output logic              o_csync_n,
  output logic              o_locked,
  output logic [LINE_W-1:0] o_line_len,
  output logic [LINE_W-1:0] o_hs_width
);

  localparam logic [LINE_W-1:0] ONE     = LINE_W'(1);
  localparam logic [LINE_W-1:0] CNT_MAX = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] MIN_LEN = LINE_W'(MIN_LINE);

  // Out-of-range EQ_LINES fails elaboration on an undefined module.
  if (EQ_LINES < 1 || EQ_LINES > 254) begin : g_eq_lines_range_error
    invalid_eq_lines_parameter u_err ();
  end

  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic [LINE_W-1:0] lc_q, lc_d;
  logic [LINE_W-1:0] wc_q, wc_d;
  logic [LINE_W-1:0] ph_q, ph_d;
  logic [LINE_W-1:0] line_len_q, line_len_d;
  logic [LINE_W-1:0] hs_width_q, hs_width_d;
  logic              locked_q, locked_d;
  logic              csync_q, csync_d;

  logic              hs_rise, hs_fall;
  logic              lc_sat, wc_sat;
  logic              meas_en, width_en;
  logic [LINE_W-1:0] meas;
  logic [LINE_W-1:0] half, hp;

  always_comb begin
    hs_d    = i_hs;
    vs_d    = i_vs;
    hs_rise = i_hs & ~hs_q;
    hs_fall = ~i_hs & hs_q;
    lc_sat  = (lc_q == CNT_MAX);
    wc_sat  = (wc_q == CNT_MAX);

    lc_d = lc_q;
    if (hs_rise)     lc_d = '0;
    else if (!lc_sat) lc_d = lc_q + ONE;

    wc_d = wc_q;
    if (i_hs) begin
      if (hs_rise)      wc_d = ONE;
      else if (!wc_sat) wc_d = wc_q + ONE;
    end

    ph_d = ph_q + ONE;
    if (hs_rise || ph_q == line_len_q - ONE) ph_d = '0;

    half = line_len_q >> 1;
    hp   = (ph_d < half) ? ph_d : ph_d - half;
  end

  // A VS edge on the HS rise cycle (either direction) suppresses measurement.
  always_comb begin
    meas     = lc_q + ONE;
    meas_en  = hs_rise & ~i_vs & ~vs_q;
    width_en = hs_fall & ~i_vs;

    locked_d   = locked_q;
    line_len_d = line_len_q;
    hs_width_d = hs_width_q;

    if (meas_en) begin
      if (lc_sat || meas < MIN_LEN) begin
        locked_d = 1'b0;
      end else if (meas == line_len_q) begin
        locked_d = 1'b1;
      end else begin
        line_len_d = meas;
        locked_d   = 1'b0;
      end
    end

    if (width_en) begin
      hs_width_d = wc_q;
      if (wc_q != hs_width_q) locked_d = 1'b0;
    end

    if (lc_sat) locked_d = 1'b0;
    if (hs_width_d >= (line_len_d >> 1)) locked_d = 1'b0;
  end

`ifdef CSYNC_EQ_EN
  localparam logic [7:0] EQ_LOAD      = 8'(EQ_LINES);
  localparam logic [7:0] EQ_LOAD_LATE = 8'(EQ_LINES + 1);

  logic [7:0] eq_cnt_q, eq_cnt_d;
  logic       eq_on;

  // A VS fall mid-line loads one extra so only full lines get equalizing pulses.
  always_comb begin
    eq_cnt_d = eq_cnt_q;
    if (!locked_q || (i_vs && !vs_q)) begin
      eq_cnt_d = '0;
    end else if (!i_vs && vs_q) begin
      eq_cnt_d = (ph_d == '0) ? EQ_LOAD : EQ_LOAD_LATE;
    end else if (ph_d == '0 && eq_cnt_q != '0) begin
      eq_cnt_d = eq_cnt_q - 8'd1;
    end
    eq_on = (eq_cnt_d != '0) && (eq_cnt_d <= EQ_LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) eq_cnt_q <= '0;
    else       eq_cnt_q <= eq_cnt_d;
  end
`endif

  always_comb begin
    if (!locked_q) begin
      csync_d = ~(i_hs ^ i_vs);
    end else if (i_vs) begin
      csync_d = (hp >= (half - hs_width_q));
`ifdef CSYNC_EQ_EN
    end else if (eq_on) begin
      csync_d = (hp >= (hs_width_q >> 1));
`endif
    end else begin
      csync_d = ~i_hs;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      lc_q       <= '0;
      wc_q       <= '0;
      ph_q       <= '0;
      line_len_q <= '0;
      hs_width_q <= '0;
      locked_q   <= 1'b0;
      csync_q    <= 1'b1;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      lc_q       <= lc_d;
      wc_q       <= wc_d;
      ph_q       <= ph_d;
      line_len_q <= line_len_d;
      hs_width_q <= hs_width_d;
      locked_q   <= locked_d;
      csync_q    <= csync_d;
    end
  end

  assign o_csync_n  = csync_q;
  assign o_locked   = locked_q;
  assign o_line_len = line_len_q;
  assign o_hs_width = hs_width_q;

endmodule

// File: tb/tb_analogizer_csync_gen.sv
// Directed bench for analogizer_csync_gen: lock acquisition, serration, line
// length changes, short lines, lc saturation and mid-frame reset.
module tb_analogizer_csync_gen;

`ifdef CSYNC_EQ_EN
  localparam int POST_VS_MODE = 3;
`else
  localparam int POST_VS_MODE = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs  = 1'b0;
  logic        vs  = 1'b0;
  logic        o_csync_n;
  logic        o_locked;
  logic [11:0] o_line_len;
  logic [11:0] o_hs_width;

  int          checks = 0;
  int          errors = 0;
  logic        lk_first;
  logic [11:0] len_first;

  analogizer_csync_gen #(.LINE_W(12), .MIN_LINE(64), .EQ_LINES(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_hs       (hs),
    .i_vs       (vs),
    .o_csync_n  (o_csync_n),
    .o_locked   (o_locked),
    .o_line_len (o_line_len),
    .o_hs_width (o_hs_width)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mode 1: ~hs. Mode 2: serration of a 768/64 line. Mode 3: equalizing of a 768/64 line.
  function automatic logic exp_cs(input int mode, input int c, input int hsw);
    case (mode)
      2:       return !((c < 320) || (c >= 384 && c < 704));
      3:       return !((c < 32) || (c >= 384 && c < 416));
      default: return !(c < hsw);
    endcase
  endfunction

  task automatic run_line(input string tag, input int len, input int hsw, input logic v,
                          input int mode);
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    for (int c = 0; c < len; c++) begin
      hs = (c < hsw);
      vs = v;
      step();
      if (c == 0) begin
        lk_first  = o_locked;
        len_first = o_line_len;
      end
      if (mode != 0 && o_csync_n !== exp_cs(mode, c, hsw)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    if (mode != 0) chk($sformatf("%s bad_cycles(first_c=%0d)", tag, first_bad), bad, 0);
  endtask

  task automatic idle(input string tag, input int n, input logic v, input logic exp);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      hs = 1'b0;
      vs = v;
      step();
      if (o_csync_n !== exp) bad++;
    end
    chk($sformatf("%s bad_cycles", tag), bad, 0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0;
    repeat (3) step();
    chk("rst_csync", o_csync_n, 1);
    chk("rst_locked", o_locked, 0);
    chk("rst_line_len", o_line_len, 0);
    chk("rst_hs_width", o_hs_width, 0);

    rst = 1'b0;
    repeat (2) step();
    hs = 1'b1; vs = 1'b0; step();
    chk("prelock_hs", o_csync_n, 0);
    step();
    hs = 1'b1; vs = 1'b1; step();
    chk("prelock_hs_vs", o_csync_n, 1);
    step();
    hs = 1'b0; vs = 1'b1; step();
    chk("prelock_vs", o_csync_n, 0);
    idle("prelock_idle", 10, 1'b0, 1'b1);

    run_line("line_a", 768, 64, 1'b0, 0);
    chk("a_locked", lk_first, 0);
    run_line("line_b", 768, 64, 1'b0, 1);
    chk("b_locked", lk_first, 0);
    chk("b_line_len", len_first, 768);
    chk("b_hs_width", o_hs_width, 64);
    run_line("line_c", 768, 64, 1'b0, 1);
    chk("c_locked", lk_first, 1);

    run_line("serr_d", 768, 64, 1'b1, 2);
    chk("d_locked", lk_first, 1);
    run_line("serr_e", 768, 64, 1'b1, 2);
    run_line("serr_f", 768, 64, 1'b1, 2);
    chk("f_locked", o_locked, 1);

    run_line("post_vs_g", 768, 64, 1'b0, POST_VS_MODE);
    run_line("post_vs_h", 768, 64, 1'b0, POST_VS_MODE);
    run_line("post_vs_i", 768, 64, 1'b0, POST_VS_MODE);
    run_line("normal_j", 768, 64, 1'b0, 1);
    chk("j_locked", lk_first, 1);

    run_line("len770_k", 770, 64, 1'b0, 1);
    chk("k_locked", lk_first, 1);
    run_line("len770_l", 770, 64, 1'b0, 1);
    chk("l_locked", lk_first, 0);
    chk("l_line_len", len_first, 770);
    run_line("len770_m", 770, 64, 1'b0, 1);
    chk("m_locked", lk_first, 1);

    for (int n = 0; n < 4; n++) run_line("short40", 40, 8, 1'b0, 1);
    chk("short_locked", o_locked, 0);
    chk("short_line_len", o_line_len, 770);
    chk("short_hs_width", o_hs_width, 8);

    run_line("relock_p", 768, 64, 1'b0, 1);
    run_line("relock_q", 768, 64, 1'b0, 1);
    chk("q_locked", lk_first, 0);
    chk("q_line_len", len_first, 768);
    run_line("relock_r", 768, 64, 1'b0, 1);
    chk("r_locked", lk_first, 1);

    run_line("sat_pre", 4000, 64, 1'b0, 1);
    chk("sat_pre_locked", o_locked, 1);
    idle("sat_idle", 300, 1'b0, 1'b1);
    chk("sat_locked", o_locked, 0);
    idle("sat_xnor_vs", 768, 1'b1, 1'b0);
    idle("sat_xnor", 5, 1'b0, 1'b1);

    run_line("relock_s", 768, 64, 1'b0, 1);
    chk("s_locked", lk_first, 0);
    run_line("relock_t", 768, 64, 1'b0, 1);
    chk("t_locked", lk_first, 1);
    run_line("serr_u", 768, 64, 1'b1, 2);

    for (int c = 0; c < 10; c++) begin
      hs = 1'b1; vs = 1'b0; step();
    end
    rst = 1'b1; hs = 1'b1; step();
    chk("midrst_csync", o_csync_n, 1);
    chk("midrst_locked", o_locked, 0);
    chk("midrst_line_len", o_line_len, 0);
    chk("midrst_hs_width", o_hs_width, 0);
    rst = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (3) step();

    run_line("after_rst_w", 768, 64, 1'b0, 1);
    chk("w_locked", lk_first, 0);
    run_line("after_rst_x", 768, 64, 1'b0, 1);
    chk("x_locked", lk_first, 0);
    chk("x_line_len", len_first, 768);
    run_line("after_rst_y", 768, 64, 1'b0, 1);
    chk("y_locked", lk_first, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
